// File: rtl/avaliador_licao_pkg.sv
// Shared definitions for the piano lesson evaluator.
// Holds the FSM state codes, the BPM-to-half-beat divisor, the note width
// helper and the one-hot decode / lowest-key encode functions used by the
// LED decoders and the key capture logic.
package avaliador_licao_pkg;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    BUSCA    = 4'd2,
    ESPERA   = 4'd3,
    REGISTRA = 4'd4,
    COMPARA  = 4'd5,
    FEEDBACK = 4'd6,
    PROXIMO  = 4'd7,
    FIM      = 4'd8
  } estado_t;

  // Upper bound on key count handled by the generic decode/encode helpers.
  localparam int MAX_KEYS   = 64;
  localparam int NOTA_MAX_W = 8;

  // Width of a note code: 0 = no note, k = key k-1.
  function automatic int nota_w(input int n_keys);
    return $clog2(n_keys + 1);
  endfunction

  // Cycles per half-beat for a BPM selection, floor(clock*60/(2*bpm)).
  function automatic longint hb_ciclos(input longint clock_freq, input logic [1:0] bpm_sel);
    longint bpm;
    case (bpm_sel)
      2'b00:   bpm = 64'sd60;
      2'b01:   bpm = 64'sd90;
      2'b10:   bpm = 64'sd120;
      2'b11:   bpm = 64'sd180;
      default: bpm = 64'sd60;
    endcase
    return (clock_freq * 64'sd60) / (64'sd2 * bpm);
  endfunction

  // Note code -> one-hot key vector (code 0 lights nothing).
  function automatic logic [MAX_KEYS-1:0] decode_nota(input logic [NOTA_MAX_W-1:0] nota);
    logic [MAX_KEYS-1:0] oh;
    oh = '0;
    for (int k = 0; k < MAX_KEYS; k++) begin
      oh[k] = (int'(nota) == (k + 1));
    end
    return oh;
  endfunction

  // Key vector -> note code of the lowest pressed key (0 if none).
  function automatic logic [NOTA_MAX_W-1:0] encode_nota(input logic [MAX_KEYS-1:0] teclas);
    logic [NOTA_MAX_W-1:0] n;
    n = '0;
    for (int k = MAX_KEYS - 1; k >= 0; k--) begin
      if (teclas[k]) begin
        n = NOTA_MAX_W'(k + 1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/avaliador_licao_temporizador_batida.sv
// Beat timer: divides the clock down to half-beats for the selected BPM and
// keeps a saturating half-beat count.
// Ports: clock/reset (async active-low), bpm_sel_i (latched tempo),
// zera_i (clear count and divider), conta_i (advance while high),
// hb_o (half-beats elapsed, saturating), meio_o (toggles each half-beat).
module avaliador_licao_temporizador_batida
  import avaliador_licao_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int TEMPO_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         bpm_sel_i,
  input  logic               zera_i,
  input  logic               conta_i,
  output logic [TEMPO_W+1:0] hb_o,
  output logic               meio_o
);

  localparam longint HB0   = hb_ciclos(longint'(CLOCK_FREQ), 2'b00);
  localparam longint HB1   = hb_ciclos(longint'(CLOCK_FREQ), 2'b01);
  localparam longint HB2   = hb_ciclos(longint'(CLOCK_FREQ), 2'b10);
  localparam longint HB3   = hb_ciclos(longint'(CLOCK_FREQ), 2'b11);
  // 60 BPM has the longest half-beat, so it sizes the divider.
  localparam int     DIV_W = $clog2(HB0 + 64'sd1);

  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   limite_s;
  logic [TEMPO_W+1:0] hb_q;
  logic               meio_q;

  // Last divider value of a half-beat for the latched tempo.
  always_comb begin
    limite_s = '0;
    case (bpm_sel_i)
      2'b00:   limite_s = DIV_W'(HB0 - 64'sd1);
      2'b01:   limite_s = DIV_W'(HB1 - 64'sd1);
      2'b10:   limite_s = DIV_W'(HB2 - 64'sd1);
      2'b11:   limite_s = DIV_W'(HB3 - 64'sd1);
      default: limite_s = DIV_W'(HB0 - 64'sd1);
    endcase
  end

  // Divider and saturating half-beat counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      hb_q   <= '0;
      meio_q <= 1'b0;
    end else if (zera_i) begin
      div_q  <= '0;
      hb_q   <= '0;
      meio_q <= 1'b0;
    end else if (conta_i) begin
      if (div_q == limite_s) begin
        div_q  <= '0;
        meio_q <= ~meio_q;
        if (hb_q != {(TEMPO_W+2){1'b1}}) begin
          hb_q <= hb_q + {{(TEMPO_W+1){1'b0}}, 1'b1};
        end
      end else begin
        div_q <= div_q + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign hb_o   = hb_q;
  assign meio_o = meio_q;

endmodule

// File: rtl/avaliador_licao.sv
// Piano lesson evaluator: walks a stored song, waits for a key press per
// note, grades note and timing, and keeps hit/error scores.
// Ports: clock, reset (async active-low), iniciar (start), bpm_sel (tempo,
// latched on start), modo_guiado (light expected note), botoes (raw keys),
// tamanho (last note index), mem_addr/mem_nota/mem_tempo (song RAM, one
// cycle read latency), leds (one-hot), nota_ok/tempo_ok (last grade),
// acertos/erros (scores), pronto (done), timeout (aborted), db_estado.
module avaliador_licao
  import avaliador_licao_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int N_KEYS       = 12,
  parameter int ADDR_W       = 4,
  parameter int TEMPO_W      = 4,
  parameter int TOL_HALF     = 1,
  parameter int TIMEOUT_S    = 5,
  parameter int FEEDBACK_DIV = 2,
  // Derived from N_KEYS; not meant to be overridden.
  parameter int NOTE_W       = nota_w(N_KEYS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic [1:0]         bpm_sel,
  input  logic               modo_guiado,
  input  logic [N_KEYS-1:0]  botoes,
  input  logic [ADDR_W-1:0]  tamanho,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [NOTE_W-1:0]  mem_nota,
  input  logic [TEMPO_W-1:0] mem_tempo,
  output logic [N_KEYS-1:0]  leds,
  output logic               nota_ok,
  output logic               tempo_ok,
  output logic [ADDR_W:0]    acertos,
  output logic [ADDR_W:0]    erros,
  output logic               pronto,
  output logic               timeout,
  output logic [3:0]         db_estado
);

  localparam longint TO_LIMIT = longint'(TIMEOUT_S) * longint'(CLOCK_FREQ);
  localparam longint FB_LIMIT = longint'(CLOCK_FREQ / FEEDBACK_DIV);
  localparam longint CNT_MAX  = (TO_LIMIT > FB_LIMIT) ? TO_LIMIT : FB_LIMIT;
  localparam int     CNT_W    = $clog2(CNT_MAX + 64'sd1);
  // Signed width wide enough for hb - 2*mem_tempo without overflow.
  localparam int     DW       = TEMPO_W + 3;

  estado_t              estado_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W:0]      acertos_q;
  logic [ADDR_W:0]      erros_q;
  logic                 nota_ok_q;
  logic                 tempo_ok_q;
  logic                 pronto_q;
  logic                 timeout_q;
  logic [1:0]           bpm_q;
  logic [NOTE_W-1:0]    nota_cap_q;
  logic [TEMPO_W+1:0]   hb_cap_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tecla_ant_q;
  logic                 evento_q;
  logic [NOTE_W-1:0]    nota_ev_q;
  logic [N_KEYS-1:0]    leds_q;
  logic [N_KEYS-1:0]    leds_d;

  logic [TEMPO_W+1:0]    hb_s;
  logic                  meio_s;
  logic [NOTA_MAX_W-1:0] enc_s;
  logic [MAX_KEYS-1:0]   dec_esp_s;
  logic [MAX_KEYS-1:0]   dec_fb_s;
  logic signed [DW-1:0]  dif_s;
  logic [DW-1:0]         abs_s;
  logic                  tempo_ok_s;

  // The half-beat count restarts on the cycle before every ESPERA entry.
  avaliador_licao_temporizador_batida #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .TEMPO_W    (TEMPO_W)
  ) u_temporizador_batida (
    .clock     (clock),
    .reset     (reset),
    .bpm_sel_i (bpm_q),
    .zera_i    (estado_q == BUSCA),
    .conta_i   (estado_q == ESPERA),
    .hb_o      (hb_s),
    .meio_o    (meio_s)
  );

  assign enc_s     = encode_nota(MAX_KEYS'(botoes));
  assign dec_esp_s = decode_nota(NOTA_MAX_W'(mem_nota));
  assign dec_fb_s  = decode_nota(NOTA_MAX_W'(nota_cap_q));

  // Rising edge of "any key down"; held keys never retrigger.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tecla_ant_q <= 1'b0;
      evento_q    <= 1'b0;
      nota_ev_q   <= '0;
    end else begin
      tecla_ant_q <= |botoes;
      evento_q    <= (|botoes) & ~tecla_ant_q;
      nota_ev_q   <= enc_s[NOTE_W-1:0];
    end
  end

  // Timing error in half-beats against the target 2*mem_tempo.
  always_comb begin
    dif_s = signed'(DW'(hb_cap_q)) - signed'(DW'({mem_tempo, 1'b0}));
    if (dif_s < 0) begin
      abs_s = DW'(-dif_s);
    end else begin
      abs_s = DW'(dif_s);
    end
    tempo_ok_s = (abs_s <= DW'(TOL_HALF));
  end

  // LED source: guide note while waiting, captured note during feedback.
  always_comb begin
    leds_d = '0;
    if ((estado_q == ESPERA) && modo_guiado) begin
      leds_d = dec_esp_s[N_KEYS-1:0];
    end else if (estado_q == FEEDBACK) begin
      leds_d = dec_fb_s[N_KEYS-1:0];
    end else begin
      leds_d = '0;
    end
  end

  // Lesson sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      addr_q     <= '0;
      acertos_q  <= '0;
      erros_q    <= '0;
      nota_ok_q  <= 1'b0;
      tempo_ok_q <= 1'b0;
      pronto_q   <= 1'b0;
      timeout_q  <= 1'b0;
      bpm_q      <= 2'b00;
      nota_cap_q <= '0;
      hb_cap_q   <= '0;
      cnt_q      <= '0;
      leds_q     <= '0;
    end else begin
      leds_q <= leds_d;
      case (estado_q)
        INICIAL: begin
          if (iniciar) begin
            estado_q <= PREPARA;
          end
        end
        PREPARA: begin
          addr_q     <= '0;
          acertos_q  <= '0;
          erros_q    <= '0;
          nota_ok_q  <= 1'b0;
          tempo_ok_q <= 1'b0;
          pronto_q   <= 1'b0;
          timeout_q  <= 1'b0;
          bpm_q      <= bpm_sel;
          estado_q   <= BUSCA;
        end
        BUSCA: begin
          cnt_q    <= '0;
          estado_q <= ESPERA;
        end
        ESPERA: begin
          // A press in the same cycle as the timeout takes priority.
          if (evento_q) begin
            nota_cap_q <= nota_ev_q;
            hb_cap_q   <= hb_s;
            estado_q   <= REGISTRA;
          end else if (cnt_q == CNT_W'(TO_LIMIT - 64'sd1)) begin
            timeout_q <= 1'b1;
            pronto_q  <= 1'b1;
            estado_q  <= FIM;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        REGISTRA: begin
          nota_ok_q  <= (nota_cap_q == mem_nota);
          tempo_ok_q <= tempo_ok_s;
          estado_q   <= COMPARA;
        end
        COMPARA: begin
          if (nota_ok_q && tempo_ok_q) begin
            acertos_q <= acertos_q + {{ADDR_W{1'b0}}, 1'b1};
          end else begin
            erros_q <= erros_q + {{ADDR_W{1'b0}}, 1'b1};
          end
          cnt_q    <= '0;
          estado_q <= FEEDBACK;
        end
        FEEDBACK: begin
          if (cnt_q == CNT_W'(FB_LIMIT - 64'sd1)) begin
            if (addr_q == tamanho) begin
              pronto_q <= 1'b1;
              estado_q <= FIM;
            end else begin
              estado_q <= PROXIMO;
            end
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        PROXIMO: begin
          addr_q   <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          estado_q <= BUSCA;
        end
        FIM: begin
          if (iniciar) begin
            estado_q <= PREPARA;
          end
        end
        default: begin
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign leds      = leds_q;
  assign nota_ok   = nota_ok_q;
  assign tempo_ok  = tempo_ok_q;
  assign acertos   = acertos_q;
  assign erros     = erros_q;
  assign pronto    = pronto_q;
  assign timeout   = timeout_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_avaliador_licao.sv
module tb_avaliador_licao;

  localparam int CLK_F = 1000;
  localparam int TOL   = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [1:0]  bpm_sel;
  logic        modo_guiado;
  logic [11:0] botoes;
  logic [3:0]  tamanho;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_nota;
  logic [3:0]  mem_tempo;
  logic [11:0] leds;
  logic        nota_ok;
  logic        tempo_ok;
  logic [4:0]  acertos;
  logic [4:0]  erros;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  avaliador_licao #(
    .CLOCK_FREQ(CLK_F), .N_KEYS(12), .ADDR_W(4), .TEMPO_W(4),
    .TOL_HALF(TOL), .TIMEOUT_S(5), .FEEDBACK_DIV(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .bpm_sel(bpm_sel),
    .modo_guiado(modo_guiado), .botoes(botoes), .tamanho(tamanho),
    .mem_addr(mem_addr), .mem_nota(mem_nota), .mem_tempo(mem_tempo),
    .leds(leds), .nota_ok(nota_ok), .tempo_ok(tempo_ok), .acertos(acertos),
    .erros(erros), .pronto(pronto), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Song RAM model with one cycle of read latency.
  logic [3:0] nota_mem  [16];
  logic [3:0] tempo_mem [16];
  always @(posedge clock) begin
    mem_nota  <= nota_mem[mem_addr];
    mem_tempo <= tempo_mem[mem_addr];
  end

  // Lesson plan: key mask per note (0 = never press), half-beat target, hold flag.
  logic [11:0] plan_key  [16];
  int          plan_k    [16];
  logic        plan_hold [16];

  typedef struct {int ac; int er; int to; int addr;} fim_t;
  logic [1:0] grade_q [$];
  fim_t       final_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
    end
  endtask

  function automatic int hb_of(input logic [1:0] b);
    int bpm;
    bpm = (b == 2'd0) ? 60 : (b == 2'd1) ? 90 : (b == 2'd2) ? 120 : 180;
    return (CLK_F * 60) / (2 * bpm);
  endfunction

  function automatic logic [11:0] onehot(input int nota);
    logic [11:0] v;
    v = '0;
    if (nota > 0) v[nota-1] = 1'b1;
    return v;
  endfunction

  function automatic int menor_tecla(input logic [11:0] m);
    for (int k = 0; k < 12; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic espera_estado(input logic [3:0] st, input int maxc, output int n);
    n = 0;
    while (db_estado !== st && n < maxc) begin
      @(negedge clock);
      n++;
    end
    if (db_estado !== st) chk("espera_estado", db_estado, st);
  endtask

  // Monitor: grades are checked when COMPARA is presented, final scores in FIM.
  logic [3:0] prev_est = 4'd0;
  int         fim_n = 0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_est = 4'd0;
      fim_n    = 0;
    end else begin
      if (db_estado == 4'd5 && prev_est != 4'd5) begin
        chk("fila_notas", grade_q.size(), 1);
        if (grade_q.size() > 0) begin
          logic [1:0] g;
          g = grade_q.pop_front();
          chk("nota_ok", nota_ok, g[1]);
          chk("tempo_ok", tempo_ok, g[0]);
        end
      end
      if (db_estado == 4'd8) fim_n++; else fim_n = 0;
      if (fim_n == 2) begin
        chk("fila_fim", final_q.size(), 1);
        if (final_q.size() > 0) begin
          fim_t f;
          f = final_q.pop_front();
          chk("acertos", acertos, f.ac);
          chk("erros", erros, f.er);
          chk("timeout", timeout, f.to);
          chk("pronto", pronto, 1);
          chk("mem_addr_fim", mem_addr, f.addr);
          chk("leds_fim", leds, 0);
        end
      end
      prev_est = db_estado;
    end
  end

  task automatic pulso_iniciar();
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
  endtask

  // Runs one lesson from the plan; expectations come from the grading rules.
  task automatic licao(input logic [1:0] bsel, input int tam, input logic guiado);
    int ac, er, hbc, d, used, n, k, nota, tv;
    logic nok, tok;
    logic [11:0] m;
    ac = 0; er = 0; hbc = hb_of(bsel);
    tamanho = 4'(tam); bpm_sel = bsel; modo_guiado = guiado;
    pulso_iniciar();
    for (int i = 0; i <= tam; i++) begin
      espera_estado(4'd3, 1000, n);
      chk("endereco", mem_addr, i);
      used = 0;
      if (i > 0 && plan_hold[i-1]) begin
        repeat (200) @(negedge clock);
        chk("tecla_presa", db_estado, 3);
        botoes = '0;
        used = 200;
      end
      repeat (5) @(negedge clock);
      used += 5;
      chk("leds_guia", leds, guiado ? onehot(nota_mem[i]) : 12'd0);
      m = plan_key[i];
      if (m == 12'd0) begin
        final_q.push_back('{ac, er, 1, i});
        espera_estado(4'd8, 6000, n);
        chk("ciclos_timeout", used + n, 5000);
        repeat (5) @(negedge clock);
        return;
      end
      k = plan_k[i];
      d = k * hbc + hbc / 2;
      repeat (d - used) @(negedge clock);
      botoes = m;
      nota = menor_tecla(m) + 1;
      nok  = (nota == int'(nota_mem[i]));
      tv   = k - 2 * int'(tempo_mem[i]);
      tok  = (tv <= TOL) && (tv >= -TOL);
      grade_q.push_back({nok, tok});
      if (nok && tok) ac++; else er++;
      if (i == tam) final_q.push_back('{ac, er, 0, tam});
      espera_estado(4'd6, 20, n);
      repeat (3) @(negedge clock);
      chk("leds_retorno", leds, onehot(nota));
      if (!plan_hold[i]) botoes = '0;
    end
    espera_estado(4'd8, 1000, n);
    repeat (5) @(negedge clock);
  endtask

  task automatic limpa_plano();
    for (int i = 0; i < 16; i++) begin
      plan_key[i] = '0; plan_k[i] = 0; plan_hold[i] = 1'b0;
      nota_mem[i] = '0; tempo_mem[i] = '0;
    end
  endtask

  initial begin
    #(1000000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, k, tam;
    reset = 1'b0; iniciar = 1'b0; bpm_sel = 2'b00; modo_guiado = 1'b0;
    botoes = '0; tamanho = '0;
    limpa_plano();
    #1;
    chk("rst_estado", db_estado, 0);
    chk("rst_leds", leds, 0);
    chk("rst_acertos", acertos, 0);
    chk("rst_erros", erros, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_addr", mem_addr, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Perfect song at 120 BPM.
    limpa_plano();
    nota_mem[0] = 4'd1;  tempo_mem[0] = 4'd1; plan_key[0] = 12'h001; plan_k[0] = 2;
    nota_mem[1] = 4'd5;  tempo_mem[1] = 4'd2; plan_key[1] = 12'h010; plan_k[1] = 4;
    nota_mem[2] = 4'd12; tempo_mem[2] = 4'd1; plan_key[2] = 12'h800; plan_k[2] = 2;
    licao(2'b10, 2, 1'b1);

    // Tolerance window and wrong note.
    limpa_plano();
    for (int i = 0; i < 4; i++) begin nota_mem[i] = 4'd5; tempo_mem[i] = 4'd2; plan_key[i] = 12'h010; end
    plan_k[0] = 5; plan_k[1] = 6; plan_k[2] = 3;
    plan_key[3] = 12'h040; plan_k[3] = 4;
    licao(2'b10, 3, 1'b0);

    // Timeout on the second note.
    limpa_plano();
    nota_mem[0] = 4'd7; tempo_mem[0] = 4'd1; plan_key[0] = 12'h040; plan_k[0] = 2;
    nota_mem[1] = 4'd2; tempo_mem[1] = 4'd1;
    licao(2'b11, 3, 1'b1);

    // Lowest key wins; a held key does not retrigger.
    limpa_plano();
    nota_mem[0] = 4'd3; tempo_mem[0] = 4'd1; plan_key[0] = 12'h084; plan_k[0] = 2; plan_hold[0] = 1'b1;
    nota_mem[1] = 4'd8; tempo_mem[1] = 4'd2; plan_key[1] = 12'h080; plan_k[1] = 4;
    licao(2'b10, 1, 1'b1);

    // Randomized lessons.
    for (int r = 0; r < 2; r++) begin
      limpa_plano();
      tam = $urandom_range(1, 5);
      for (int i = 0; i <= tam; i++) begin
        nota_mem[i]  = 4'($urandom_range(0, 12));
        t            = $urandom_range(0, 2);
        tempo_mem[i] = 4'(t);
        k = 2 * t + $urandom_range(0, 4) - 2;
        plan_k[i] = (k < 0) ? 0 : k;
        if (nota_mem[i] != 4'd0 && $urandom_range(0, 1) == 1) plan_key[i] = onehot(nota_mem[i]);
        else plan_key[i] = onehot($urandom_range(1, 12));
        if ($urandom_range(0, 3) == 0) plan_key[i] = plan_key[i] | onehot($urandom_range(1, 12));
      end
      licao(2'($urandom_range(0, 3)), tam, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of FEEDBACK.
    limpa_plano();
    nota_mem[0] = 4'd4; tempo_mem[0] = 4'd1; plan_key[0] = 12'h008; plan_k[0] = 2;
    nota_mem[1] = 4'd9; tempo_mem[1] = 4'd1; plan_key[1] = 12'h100; plan_k[1] = 2;
    tamanho = 4'd2; bpm_sel = 2'b11; modo_guiado = 1'b1;
    pulso_iniciar();
    espera_estado(4'd3, 100, n);
    repeat (2 * hb_of(2'b11) + 50) @(negedge clock);
    botoes = 12'h008;
    grade_q.push_back({1'b1, 1'b1});
    espera_estado(4'd6, 20, n);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_estado", db_estado, 0);
    chk("rst_mid_leds", leds, 0);
    chk("rst_mid_acertos", acertos, 0);
    chk("rst_mid_nota_ok", nota_ok, 0);
    chk("rst_mid_tempo_ok", tempo_ok, 0);
    chk("rst_mid_addr", mem_addr, 0);
    grade_q.delete();
    final_q.delete();
    botoes = '0;
    @(negedge clock); reset = 1'b1;
    plan_k[0] = 1; plan_key[0] = 12'h001;
    plan_k[1] = 2;
    licao(2'b11, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avaliador_licao.md
Name: avaliador_licao

Overview:
- Parametrised successor of the piano lesson datapath: a self-sequencing evaluator that steps through a stored song, waits for key presses, and grades each note and its timing.
- Generalised in key count, song depth, tempo width, BPM mode (4 tempos) and timing tolerance.
- Adds a built-in controller, hit/error scoring and a guided mode.
- Sits between the key inputs, the external note/tempo RAMs and the buzzer/LED output.

Parameters:
CLOCK_FREQ, 50000000, clock frequency in Hz
N_KEYS, 12, number of piano keys
ADDR_W, 4, song address width (max 2^ADDR_W notes)
TEMPO_W, 4, width of the stored expected-beat value
TOL_HALF, 1, allowed timing error in half-beats (inclusive)
TIMEOUT_S, 5, seconds without a press before the lesson aborts
FEEDBACK_DIV, 2, feedback hold time = CLOCK_FREQ/FEEDBACK_DIV cycles

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start lesson (level, sampled per cycle)
bpm_sel  input  2  00=60, 01=90, 10=120, 11=180 BPM; sampled on start
modo_guiado  input  1  1 = light the expected note while waiting
botoes  input  N_KEYS  raw key levels
tamanho  input  ADDR_W  index of the last note in the song
mem_addr  output  ADDR_W  RAM address
mem_nota  input  NOTE_W  expected note; NOTE_W = clog2(N_KEYS+1); value k = key k-1; 0 = no-note
mem_tempo  input  TEMPO_W  expected beats since note window start
leds  output  N_KEYS  one-hot LED drive
nota_ok  output  1  last graded note matched
tempo_ok  output  1  last graded timing within tolerance
acertos  output  ADDR_W+1  notes with both note and timing correct
erros  output  ADDR_W+1  graded notes not counted as acertos
pronto  output  1  lesson finished
timeout  output  1  lesson aborted by timeout
db_estado  output  4  state code

Behaviour:
Reset (reset=0, asynchronous):
- State INICIAL.
- All outputs and internal counters 0.
- Edge detector history cleared.

Timing:
- Half-beat period HB = CLOCK_FREQ*60/(2*BPM), integer floor.
- Half-beat counter hb, width TEMPO_W+2, saturating. Zeroed on every ESPERA entry; +1 per HB cycles while in ESPERA.
- Timeout counter runs only in ESPERA, zeroed on entry. Fires at TIMEOUT_S*CLOCK_FREQ cycles.

Key capture:
- Press event = rising edge of OR(botoes), registered in one cycle.
- Captured note = lowest set key index + 1.
- Held keys never generate a new event.
- Events outside ESPERA are discarded.

States:
- INICIAL: iniciar=1 -> PREPARA.
- PREPARA (1 cycle): mem_addr, acertos, erros, nota_ok, tempo_ok, pronto, timeout <= 0; latch bpm_sel. -> BUSCA.
- BUSCA (1 cycle): RAM read latency. -> ESPERA.
- ESPERA: leds = decode(mem_nota) if modo_guiado, else 0.
  - Press event -> REGISTRA; latch the note and hb.
  - Timeout -> FIM with timeout=1.
  - If both occur in the same cycle, the press wins.
- REGISTRA (1 cycle):
  - nota_ok <= (note==mem_nota).
  - tempo_ok <= |hb - 2*mem_tempo| <= TOL_HALF, computed signed and at least TEMPO_W+3 bits wide.
  - -> COMPARA.
- COMPARA (1 cycle): acertos+1 if nota_ok&tempo_ok, else erros+1. -> FEEDBACK.
- FEEDBACK: leds = decode(captured note) for CLOCK_FREQ/FEEDBACK_DIV cycles.
  - Then -> FIM if mem_addr==tamanho, else PROXIMO.
- PROXIMO (1 cycle): mem_addr+1. -> BUSCA.
- FIM: pronto=1; leds=0; scores held. iniciar=1 -> PREPARA.

General rules:
- iniciar is ignored in all states except INICIAL and FIM.
- tamanho is used live; it must be held stable by the user during a lesson.
- mem_nota=0 is gradeable: any press gives nota_ok=0.
- Counters never wrap, since the maximum score is 2^ADDR_W.

Decomposition:
- Shared package/include holds:
  - state codes;
  - BPM-to-HB divisor function;
  - NOTE_W clog2 function;
  - the one-hot/encode decode functions used by the decoders.
- Sub-module temporizador_batida: clock divider plus saturating half-beat counter, with zera/conta inputs and a meio output for the metronome LED.

Test Plan:
Sim settings: CLOCK_FREQ=1000, TOL_HALF=1, TIMEOUT_S=5. At 120 BPM, HB=250 cycles.
1. Perfect song: tamanho=2, notes {1,5,12}, tempos {1,2,1}, 120 BPM. Press keys 0, 4, 11 at hb=2, 4, 2 -> acertos=3, erros=0, pronto=1, mem_addr=2.
2. Wrong note: expected 5, press key 6 at the correct hb -> nota_ok=0, tempo_ok=1, erros=1.
3. Tolerance: mem_tempo=2 (target hb=4). Press at hb=5 -> tempo_ok=1. Press at hb=6 -> tempo_ok=0, erros+1. Press at hb=3 -> tempo_ok=1.
4. Timeout: no press for 5000 cycles in ESPERA -> timeout=1, pronto=1, erros unchanged, leds=0.
5. Key priority and hold: keys 2 and 7 pressed together -> note 3 captured. Key held through FEEDBACK into the next ESPERA -> no event until released and re-pressed.
6. Async reset asserted mid-FEEDBACK -> outputs 0 immediately, db_estado=INICIAL. A new iniciar afterwards -> clean lesson from mem_addr=0.
